drive_sequencer: RTL and testbench

- Top-level motion controller for the kart. It arbitrates motor `mode` between the 3-way tracker output, the ultrasonic obstacle condition and a start/stop button.
- It adds three behaviours: debounced hysteretic obstacle stop, timed back-off when blocked, and lost-line recovery with timeout to halt.
- It sits between `sonic_top`/`tracker_sensor`/`buttons` and `motor`, and replaces ad-hoc glue logic at the top level.

---
 rtl/kart_pkg.sv | 50 +++++
 rtl/dist_qualifier.sv | 62 ++++++
 rtl/drive_sequencer.sv | 143 ++++++++++++++
 tb/tb_drive_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/kart_pkg.sv
// Shared definitions for the kart motion controller.
// Holds the motor mode codes, the tracker "line lost" code, the sequencer
// state encodings and small helpers used by the sequencer and its qualifier.
package kart_pkg;

    // Motor mode codes understood by the motor block.
    localparam logic [2:0] MODE_STOP  = 3'd0;
    localparam logic [2:0] MODE_FWD   = 3'd1;
    localparam logic [2:0] MODE_LEFT  = 3'd2;
    localparam logic [2:0] MODE_RIGHT = 3'd3;
    localparam logic [2:0] MODE_BACK  = 3'd4;

    // Tracker output meaning "no line under any sensor".
    localparam logic [2:0] TRK_LOST   = 3'd5;

    // Sequencer state encodings (also shown on the 7-segment display).
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GO     = 3'd1;
    localparam logic [2:0] STOP   = 3'd2;
    localparam logic [2:0] BACKUP = 3'd3;
    localparam logic [2:0] SEEK   = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    // Largest of three cycle counts, used to size the shared dwell timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Tracker request to motor mode: TRK_LOST and unused codes mean stop.
    function automatic logic [2:0] track_to_mode(input logic [2:0] trk);
        logic [2:0] m;
        case (trk)
            MODE_STOP, MODE_FWD, MODE_LEFT, MODE_RIGHT, MODE_BACK: m = trk;
            default:                                               m = MODE_STOP;
        endcase
        return m;
    endfunction

    // True for the two turn modes that seek recovery steers with.
    function automatic logic is_turn(input logic [2:0] trk);
        return (trk == MODE_LEFT) || (trk == MODE_RIGHT);
    endfunction

endpackage

// File: rtl/dist_qualifier.sv
// Debounced, hysteretic qualification of the ultrasonic distance.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   distance  - measured distance in cm (unsigned, 20 bit)
//   obstacle  - distance < STOP_CM for DEB_CYC consecutive cycles
//   clear     - distance >= GO_CM for DEB_CYC consecutive cycles
// Between STOP_CM and GO_CM both counters are held at zero, so neither
// condition can qualify inside the hysteresis band.
module dist_qualifier #(
    parameter int unsigned STOP_CM = 20,
    parameter int unsigned GO_CM   = 25,
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] distance,
    output logic        obstacle,
    output logic        clear
);

    localparam int unsigned CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [19:0]   STOP_TH = 20'(STOP_CM);
    localparam logic [19:0]   GO_TH   = 20'(GO_CM);

    logic [CW-1:0] obs_cnt_q, obs_cnt_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;

    // Next values of the two saturating debounce counters.
    always_comb begin
        obs_cnt_d = '0;
        clr_cnt_d = '0;
        if (distance < STOP_TH) begin
            if (obs_cnt_q != DEB_MAX) obs_cnt_d = obs_cnt_q + CNT_ONE;
            else                      obs_cnt_d = obs_cnt_q;
        end else begin
            obs_cnt_d = '0;
        end
        if (distance >= GO_TH) begin
            if (clr_cnt_q != DEB_MAX) clr_cnt_d = clr_cnt_q + CNT_ONE;
            else                      clr_cnt_d = clr_cnt_q;
        end else begin
            clr_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            obs_cnt_q <= '0;
            clr_cnt_q <= '0;
        end else begin
            obs_cnt_q <= obs_cnt_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign obstacle = (obs_cnt_q == DEB_MAX);
    assign clear    = (clr_cnt_q == DEB_MAX);

endmodule

// File: rtl/drive_sequencer.sv
// Kart motion sequencer: arbitrates the motor mode between the line tracker,
// the qualified ultrasonic obstacle condition and the start/stop button.
// Ports:
//   clk, rst    - 100 MHz clock, synchronous active-high reset
//   start       - single-cycle button pulse (go from IDLE/HALT, else e-stop)
//   distance    - ultrasonic distance in cm
//   track_mode  - tracker-requested mode (MODE_* or TRK_LOST)
//   mode        - registered motor mode
//   fsm_state   - current state encoding
//   obstacle    - qualified obstacle flag
//   lost        - high while in SEEK or HALT
module drive_sequencer
    import kart_pkg::*;
#(
    parameter int unsigned STOP_CM   = 20,
    parameter int unsigned GO_CM     = 25,
    parameter int unsigned DEB_CYC   = 1_000_000,
    parameter int unsigned BLOCK_CYC = 200_000_000,
    parameter int unsigned BACK_CYC  = 50_000_000,
    parameter int unsigned LOST_CYC  = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] distance,
    input  logic [2:0]  track_mode,
    output logic [2:0]  mode,
    output logic [2:0]  fsm_state,
    output logic        obstacle,
    output logic        lost
);

    localparam int unsigned DW = $clog2(max3(BLOCK_CYC, BACK_CYC, LOST_CYC) + 1);
    localparam logic [DW-1:0] T_MAX   = '1;
    localparam logic [DW-1:0] T_ONE   = DW'(1);
    localparam logic [DW-1:0] T_BLOCK = DW'(BLOCK_CYC - 1);
    localparam logic [DW-1:0] T_BACK  = DW'(BACK_CYC - 1);
    localparam logic [DW-1:0] T_LOST  = DW'(LOST_CYC - 1);

    logic          obstacle_s;
    logic          clear_s;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    last_turn_q, last_turn_d;
    logic [2:0]    mode_q, mode_d;
    logic          lost_q, lost_d;

    dist_qualifier #(
        .STOP_CM (STOP_CM),
        .GO_CM   (GO_CM),
        .DEB_CYC (DEB_CYC)
    ) u_qual (
        .clk      (clk),
        .rst      (rst),
        .distance (distance),
        .obstacle (obstacle_s),
        .clear    (clear_s)
    );

    // State, dwell timer, remembered turn and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dwell_q     <= '0;
            last_turn_q <= MODE_LEFT;
            mode_q      <= MODE_STOP;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            last_turn_q <= last_turn_d;
            mode_q      <= mode_d;
            lost_q      <= lost_d;
        end
    end

    // Next-state selection: start pulse outranks every per-state rule.
    always_comb begin
        state_d = IDLE;
        if (start) begin
            if (state_q == IDLE || state_q == HALT) state_d = GO;
            else                                   state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                GO: begin
                    if (obstacle_s)               state_d = STOP;
                    else if (track_mode == TRK_LOST) state_d = SEEK;
                    else                          state_d = GO;
                end
                STOP: begin
                    if (clear_s)                  state_d = GO;
                    else if (dwell_q == T_BLOCK)  state_d = BACKUP;
                    else                          state_d = STOP;
                end
                // Obstacle is deliberately ignored while reversing.
                BACKUP: begin
                    if (dwell_q == T_BACK) state_d = GO;
                    else                   state_d = BACKUP;
                end
                SEEK: begin
                    if (obstacle_s)                   state_d = STOP;
                    else if (track_mode != TRK_LOST)  state_d = GO;
                    else if (dwell_q == T_LOST)       state_d = HALT;
                    else                              state_d = SEEK;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Dwell timer restarts on any state change; remember the last turn seen in GO.
    always_comb begin
        dwell_d     = '0;
        last_turn_d = last_turn_q;
        if (state_d != state_q)  dwell_d = '0;
        else if (dwell_q != T_MAX) dwell_d = dwell_q + T_ONE;
        else                       dwell_d = dwell_q;
        if (state_q == GO && is_turn(track_mode)) last_turn_d = track_mode;
        else                                      last_turn_d = last_turn_q;
    end

    // Outputs decoded from the next state so they move on the same edge as it.
    always_comb begin
        mode_d = MODE_STOP;
        lost_d = 1'b0;
        case (state_d)
            GO:      mode_d = track_to_mode(track_mode);
            BACKUP:  mode_d = MODE_BACK;
            SEEK:    mode_d = last_turn_q;
            default: mode_d = MODE_STOP;
        endcase
        if (state_d == SEEK || state_d == HALT) lost_d = 1'b1;
        else                                    lost_d = 1'b0;
    end

    assign mode      = mode_q;
    assign fsm_state = state_q;
    assign obstacle  = obstacle_s;
    assign lost      = lost_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed self-checking bench for drive_sequencer with shortened timings:
// DEB_CYC=4, BLOCK_CYC=20, BACK_CYC=10, LOST_CYC=30, STOP_CM=20, GO_CM=25.
module tb_drive_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] distance;
    logic [2:0]  track_mode;
    logic [2:0]  mode;
    logic [2:0]  fsm_state;
    logic        obstacle;
    logic        lost;

    int checks = 0;
    int errors = 0;

    drive_sequencer #(
        .STOP_CM   (20),
        .GO_CM     (25),
        .DEB_CYC   (4),
        .BLOCK_CYC (20),
        .BACK_CYC  (10),
        .LOST_CYC  (30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .distance   (distance),
        .track_mode (track_mode),
        .mode       (mode),
        .fsm_state  (fsm_state),
        .obstacle   (obstacle),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; distance = 20'd100; track_mode = 3'd1;
        cyc(2);
        chk("rst_state",    32'(fsm_state), 32'd0);
        chk("rst_mode",     32'(mode),      32'd0);
        chk("rst_obstacle", 32'(obstacle),  32'd0);
        chk("rst_lost",     32'(lost),      32'd0);
        rst = 1'b0;
        cyc(1);

        // 1: start -> GO following tracker, 1-cycle latency
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t1_go_state", 32'(fsm_state), 32'd1);
        chk("t1_go_mode",  32'(mode),      32'd1);
        track_mode = 3'd3; cyc(1);
        chk("t1_right",    32'(mode),      32'd3);

        // 2: debounce and hysteresis
        distance = 20'd15; cyc(3);
        distance = 20'd100; cyc(1);
        chk("t2_short_obs_state", 32'(fsm_state), 32'd1);
        chk("t2_short_obs_flag",  32'(obstacle),  32'd0);
        distance = 20'd15; cyc(4);
        chk("t2_qual_obs_flag",  32'(obstacle),  32'd1);
        chk("t2_qual_obs_state", 32'(fsm_state), 32'd1);
        cyc(1);
        chk("t2_stop_state", 32'(fsm_state), 32'd2);
        chk("t2_stop_mode",  32'(mode),      32'd0);
        chk("t2_stop_obs",   32'(obstacle),  32'd1);
        distance = 20'd22; cyc(12);
        chk("t2_band_state", 32'(fsm_state), 32'd2);
        chk("t2_band_obs",   32'(obstacle),  32'd0);
        distance = 20'd30; cyc(4);
        chk("t2_clear_edge", 32'(fsm_state), 32'd2);
        cyc(1);
        chk("t2_rego_state", 32'(fsm_state), 32'd1);
        chk("t2_rego_mode",  32'(mode),      32'd3);

        // 3: blocked -> exactly 20 cycles STOP, 10 cycles BACKUP, GO, STOP
        distance = 20'd10; cyc(5);
        chk("t3_stop", 32'(fsm_state), 32'd2);
        cyc(19);
        chk("t3_stop_last", 32'(fsm_state), 32'd2);
        cyc(1);
        chk("t3_backup_state", 32'(fsm_state), 32'd3);
        chk("t3_backup_mode",  32'(mode),      32'd4);
        cyc(9);
        chk("t3_backup_last", 32'(fsm_state), 32'd3);
        cyc(1);
        chk("t3_go_state", 32'(fsm_state), 32'd1);
        chk("t3_go_mode",  32'(mode),      32'd3);
        cyc(1);
        chk("t3_restop", 32'(fsm_state), 32'd2);

        // 4: lost line -> SEEK, re-acquire, timeout to HALT, restart
        distance = 20'd100; cyc(5);
        chk("t4_go", 32'(fsm_state), 32'd1);
        track_mode = 3'd5; cyc(1);
        chk("t4_seek_state", 32'(fsm_state), 32'd4);
        chk("t4_seek_mode",  32'(mode),      32'd3);
        chk("t4_seek_lost",  32'(lost),      32'd1);
        cyc(11);
        chk("t4_seek_hold", 32'(fsm_state), 32'd4);
        track_mode = 3'd1; cyc(1);
        chk("t4_reacq_state", 32'(fsm_state), 32'd1);
        chk("t4_reacq_mode",  32'(mode),      32'd1);
        chk("t4_reacq_lost",  32'(lost),      32'd0);
        track_mode = 3'd5; cyc(1);
        chk("t4_seek2", 32'(fsm_state), 32'd4);
        cyc(29);
        chk("t4_seek_last", 32'(fsm_state), 32'd4);
        chk("t4_seek_turn", 32'(mode),      32'd3);
        cyc(1);
        chk("t4_halt_state", 32'(fsm_state), 32'd5);
        chk("t4_halt_mode",  32'(mode),      32'd0);
        chk("t4_halt_lost",  32'(lost),      32'd1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t4_restart_state", 32'(fsm_state), 32'd1);
        chk("t4_restart_mode",  32'(mode),      32'd0);

        // 5: obstacle beats re-acquire in SEEK; start is an e-stop elsewhere
        cyc(1);
        chk("t5_seek", 32'(fsm_state), 32'd4);
        distance = 20'd10; cyc(4);
        chk("t5_seek_obs", 32'(fsm_state), 32'd4);
        track_mode = 3'd1; cyc(1);
        chk("t5_obs_prio_state", 32'(fsm_state), 32'd2);
        chk("t5_obs_prio_mode",  32'(mode),      32'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_estop_stop_state", 32'(fsm_state), 32'd0);
        chk("t5_estop_stop_mode",  32'(mode),      32'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_go_again", 32'(fsm_state), 32'd1);
        cyc(1);
        cyc(20);
        chk("t5_backup", 32'(fsm_state), 32'd3);
        cyc(2);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t5_estop_back_state", 32'(fsm_state), 32'd0);
        chk("t5_estop_back_mode",  32'(mode),      32'd0);

        // 6: reset mid-BACKUP, then last_turn is back to LEFT
        track_mode = 3'd3;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(21);
        chk("t6_backup", 32'(fsm_state), 32'd3);
        cyc(3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t6_rst_state", 32'(fsm_state), 32'd0);
        chk("t6_rst_mode",  32'(mode),      32'd0);
        chk("t6_rst_obs",   32'(obstacle),  32'd0);
        chk("t6_rst_lost",  32'(lost),      32'd0);
        distance = 20'd100; track_mode = 3'd5;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("t6_go_lost_mode", 32'(mode), 32'd0);
        cyc(1);
        chk("t6_seek_state", 32'(fsm_state), 32'd4);
        chk("t6_seek_left",  32'(mode),      32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
